fetch_bundle_queue: RTL and testbench



---
 rtl/vliw_fetch_pkg.sv | 45 ++++
 rtl/fetch_bundle_queue_if.sv | 71 +++++++
 rtl/bundle_fifo.sv | 77 +++++++
 rtl/fetch_bundle_queue.sv | 133 +++++++++++++
 tb/tb_fetch_bundle_queue.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vliw_fetch_pkg.sv
// Shared constants and bundle entry type for the VLIW fetch/issue stage.
// The perf counter helper is only used when FETCH_PERF_EN is defined.
package vliw_fetch_pkg;

  localparam int INSN_W    = 42;
  localparam int BUNDLE_W  = 128;
  localparam int HINT_W    = 2;
  localparam int PC_MAX_W  = 32;
  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 42;
  localparam int SLOT2_LSB = 84;
  localparam int HINT_LSB  = 126;

  typedef logic [INSN_W-1:0] insn_t;

  localparam insn_t NOP_INSN = '0;

  // pc is held at the widest supported width; narrower PCs zero-extend
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    insn_t [2:0]         slots;
    logic [HINT_W-1:0]   hint;
  } bundle_entry_t;

  function automatic bundle_entry_t make_entry(
    input logic [PC_MAX_W-1:0] pc,
    input logic [BUNDLE_W-1:0] raw
  );
    bundle_entry_t e;
    e.pc       = pc;
    e.slots[0] = raw[SLOT0_LSB +: INSN_W];
    e.slots[1] = raw[SLOT1_LSB +: INSN_W];
    e.slots[2] = raw[SLOT2_LSB +: INSN_W];
    e.hint     = raw[HINT_LSB +: HINT_W];
    return e;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_bundle_queue_if.sv
// Icache, execution-unit and issue signals of the fetch/issue stage.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_bundle_queue_if #(
  parameter int PC_W = 28
);
  import vliw_fetch_pkg::*;

  logic [PC_W-1:0]     cache_PC;
  logic                cache_hit;
  logic [BUNDLE_W-1:0] cache_entry;
  logic [2:0]          eu_busy;
  logic                redirect;
  logic [PC_W-1:0]     redirect_PC;
  insn_t               eu0_instruction;
  insn_t               eu1_instruction;
  insn_t               eu2_instruction;
  logic                issue_valid;
  logic [PC_W-1:0]     issue_PC;
  logic [HINT_W-1:0]   bundle_hint;
  logic                queue_empty;
`ifdef FETCH_PERF_EN
  logic [31:0]         perf_issued;
  logic [31:0]         perf_stall;
  logic [31:0]         perf_miss;
`endif

  modport master (
    output cache_PC,
    input  cache_hit,
    input  cache_entry,
    input  eu_busy,
    input  redirect,
    input  redirect_PC,
    output eu0_instruction,
    output eu1_instruction,
    output eu2_instruction,
    output issue_valid,
    output issue_PC,
    output bundle_hint,
    output queue_empty
`ifdef FETCH_PERF_EN
    ,
    output perf_issued,
    output perf_stall,
    output perf_miss
`endif
  );

  modport slave (
    input  cache_PC,
    output cache_hit,
    output cache_entry,
    output eu_busy,
    output redirect,
    output redirect_PC,
    input  eu0_instruction,
    input  eu1_instruction,
    input  eu2_instruction,
    input  issue_valid,
    input  issue_PC,
    input  bundle_hint,
    input  queue_empty
`ifdef FETCH_PERF_EN
    ,
    input  perf_issued,
    input  perf_stall,
    input  perf_miss
`endif
  );

endinterface

// File: rtl/bundle_fifo.sv
// Synchronous DEPTH-entry bundle FIFO with flush; head is read combinationally.
// A push and pop in the same cycle at full reuse the slot being popped.
module bundle_fifo
  import vliw_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  bundle_entry_t push_data,
  output bundle_entry_t head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bundle_entry_t    mem_q [DEPTH];
  bundle_entry_t    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch/issue stage: drives fetch PC, queues icache bundles, issues 3 slots.
// Optional FETCH_PERF_EN adds saturating issued/stall/miss counters.
module fetch_bundle_queue
  import vliw_fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              PC_W     = 28,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  fetch_bundle_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              issue_valid_q, issue_valid_d;
  insn_t [2:0]       insn_q, insn_d;
  logic [PC_W-1:0]   issue_pc_q, issue_pc_d;
  logic [HINT_W-1:0] hint_q, hint_d;

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  bundle_entry_t     push_entry;
  bundle_entry_t     head_entry;
  logic              unused_pc_bits;

  bundle_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_entry),
    .count     (count)
  );

  // redirect squashes both sides of the queue for this cycle
  always_comb begin
    pop  = (count != '0) && (bus.eu_busy == 3'b000) && !bus.redirect;
    push = bus.cache_hit && !bus.redirect &&
           ((count < CNT_W'(DEPTH)) || pop);
  end

  assign push_entry = make_entry(PC_MAX_W'(fetch_pc_q), bus.cache_entry);
  assign unused_pc_bits = ^head_entry.pc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_PC;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
    end
  end

  always_comb begin
    issue_valid_d = 1'b0;
    insn_d        = {NOP_INSN, NOP_INSN, NOP_INSN};
    issue_pc_d    = issue_pc_q;
    hint_d        = hint_q;
    if (pop) begin
      issue_valid_d = 1'b1;
      insn_d        = head_entry.slots;
      issue_pc_d    = PC_W'(head_entry.pc);
      hint_d        = head_entry.hint;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      issue_valid_q <= 1'b0;
      insn_q        <= {NOP_INSN, NOP_INSN, NOP_INSN};
      issue_pc_q    <= '0;
      hint_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      issue_valid_q <= issue_valid_d;
      insn_q        <= insn_d;
      issue_pc_q    <= issue_pc_d;
      hint_q        <= hint_d;
    end
  end

  assign bus.cache_PC        = fetch_pc_q;
  assign bus.eu0_instruction = insn_q[0];
  assign bus.eu1_instruction = insn_q[1];
  assign bus.eu2_instruction = insn_q[2];
  assign bus.issue_valid     = issue_valid_q;
  assign bus.issue_PC        = issue_pc_q;
  assign bus.bundle_hint     = hint_q;
  assign bus.queue_empty     = (count == '0);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  // counters survive redirect; only rst clears them
  always_comb begin
    perf_issued_d = sat_inc(perf_issued_q, pop);
    perf_stall_d  = sat_inc(perf_stall_q,
                      (count != '0) && (bus.eu_busy != 3'b000));
    perf_miss_d   = sat_inc(perf_miss_q,
                      !bus.cache_hit && (count < CNT_W'(DEPTH)) &&
                      !bus.redirect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
      perf_miss_q   <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
      perf_miss_q   <= perf_miss_d;
    end
  end

  assign bus.perf_issued = perf_issued_q;
  assign bus.perf_stall  = perf_stall_q;
  assign bus.perf_miss   = perf_miss_q;
`endif

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Scoreboard bench for fetch_bundle_queue against a queue-level model.
// Perf counters are checked too when FETCH_PERF_EN is defined.
module tb_fetch_bundle_queue;
  import vliw_fetch_pkg::*;

  localparam int              DEPTH    = 2;
  localparam int              PC_W     = 28;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_bundle_queue_if #(.PC_W(PC_W)) bus();

  fetch_bundle_queue #(
    .DEPTH    (DEPTH),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [127:0]    raw;
  } ent_t;

  ent_t            mq[$];
  ent_t            expq[$];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_last_pc;
  logic [1:0]      m_last_hint;
  bit              known = 0;
  int              n_checks = 0;
  int              n_fail = 0;
`ifdef FETCH_PERF_EN
  logic [31:0]     m_issued, m_stall, m_miss;
`endif

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd_entry();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of stimulus; the model advances exactly as the spec describes
  task automatic cyc(input bit hit, input logic [127:0] ent,
                     input logic [2:0] busy, input bit redir,
                     input logic [PC_W-1:0] rpc, input bit r);
    bit   pop, push;
    ent_t e;
    @(negedge clk);
    if (known) begin
      chk("cache_PC", bus.cache_PC, m_pc);
      chk("queue_empty", bus.queue_empty, mq.size() == 0);
`ifdef FETCH_PERF_EN
      chk("perf_issued", bus.perf_issued, m_issued);
      chk("perf_stall", bus.perf_stall, m_stall);
      chk("perf_miss", bus.perf_miss, m_miss);
`endif
    end
    rst             = r;
    bus.cache_hit   = hit;
    bus.cache_entry = ent;
    bus.eu_busy     = busy;
    bus.redirect    = redir;
    bus.redirect_PC = rpc;
    if (r) begin
      mq.delete();
      expq.delete();
      m_pc        = RESET_PC;
      m_last_pc   = '0;
      m_last_hint = '0;
`ifdef FETCH_PERF_EN
      m_issued = 0;
      m_stall  = 0;
      m_miss   = 0;
`endif
      known = 1;
    end else begin
      pop  = mq.size() > 0 && busy == 3'b000 && !redir;
      push = hit && !redir && (mq.size() < DEPTH || pop);
`ifdef FETCH_PERF_EN
      if (pop && m_issued != 32'hFFFFFFFF) m_issued++;
      if (mq.size() > 0 && busy != 0 && m_stall != 32'hFFFFFFFF) m_stall++;
      if (!hit && mq.size() < DEPTH && !redir && m_miss != 32'hFFFFFFFF)
        m_miss++;
`endif
      if (redir) begin
        mq.delete();
        m_pc = rpc;
      end else begin
        if (pop) begin
          e = mq.pop_front();
          expq.push_back(e);
          m_last_pc   = e.pc;
          m_last_hint = e.raw[127:126];
        end
        if (push) begin
          e.pc  = m_pc;
          e.raw = ent;
          mq.push_back(e);
          m_pc = m_pc + 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 3'b000, 0, '0, 0);
  endtask

  task automatic hits(input int n, input logic [2:0] busy);
    for (int i = 0; i < n; i++) cyc(1, rnd_entry(), busy, 0, '0, 0);
  endtask

  // Monitor: every issue must match the next scoreboard entry, in order
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (known) begin
        if (bus.issue_valid === 1'b1) begin
          chk("issue_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("issue_PC", bus.issue_PC, e.pc);
            chk("slot0", bus.eu0_instruction, e.raw[41:0]);
            chk("slot1", bus.eu1_instruction, e.raw[83:42]);
            chk("slot2", bus.eu2_instruction, e.raw[125:84]);
            chk("bundle_hint", bus.bundle_hint, e.raw[127:126]);
          end
        end else begin
          chk("issue_valid", bus.issue_valid, 1'b0);
          chk("missing_issue", expq.size(), 0);
          if (expq.size() != 0) void'(expq.pop_front());
          chk("nop0", bus.eu0_instruction, NOP_INSN);
          chk("nop1", bus.eu1_instruction, NOP_INSN);
          chk("nop2", bus.eu2_instruction, NOP_INSN);
          chk("hold_PC", bus.issue_PC, m_last_pc);
          chk("hold_hint", bus.bundle_hint, m_last_hint);
        end
      end
    end
  end

  initial begin
    int r;
    rst             = 1'b1;
    bus.cache_hit   = 1'b0;
    bus.cache_entry = '0;
    bus.eu_busy     = 3'b000;
    bus.redirect    = 1'b0;
    bus.redirect_PC = '0;

    cyc(0, '0, 3'b000, 0, '0, 1);
    cyc(0, '0, 3'b000, 0, '0, 1);
    idle(2);

    // four back-to-back hits, EUs idle
    hits(4, 3'b000);
    idle(4);

    // stall on a single busy EU with continuous hits, then drain
    hits(5, 3'b010);
    idle(5);

    // redirect while the queue holds two bundles
    hits(2, 3'b111);
    cyc(1, rnd_entry(), 3'b000, 1, 28'h0000100, 0);
    hits(3, 3'b000);
    idle(4);

    // PC wrap from all-ones to zero
    cyc(0, '0, 3'b000, 1, 28'hFFFFFFF, 0);
    hits(2, 3'b000);
    idle(4);

    // alternating hit / miss
    for (int i = 0; i < 12; i++) cyc(i % 2 == 0, rnd_entry(), 3'b000, 0, '0, 0);
    idle(4);

    // reset while issuing with a full queue
    hits(2, 3'b111);
    cyc(1, rnd_entry(), 3'b000, 0, '0, 0);
    cyc(1, rnd_entry(), 3'b000, 0, '0, 1);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      cyc($urandom_range(0, 99) < 70, rnd_entry(),
          ($urandom_range(0, 99) < 30) ? 3'($urandom) : 3'b000,
          r < 5,
          (r < 2) ? 28'hFFFFFFE : 28'($urandom),
          r == 99);
    end
    idle(8);

    @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
